// File: rtl/block_pkg.sv
// Shared types and elaboration helpers for the block packer datapath.
package block_pkg;

    // Packer control state: ACCUM takes input beats, TAIL emits the leftover
    // blocks of a packet whose last beat overflowed one output word.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        TAIL  = 1'b1
    } state_t;

    // Width of a counter that must represent every value 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Legal geometry: at least one lane, and an output word must hold a full beat.
    function automatic bit params_ok(input int num_lanes, input int out_blocks);
        return (num_lanes >= 1) && (out_blocks >= num_lanes);
    endfunction

endpackage

// File: rtl/block_packer_lane_compactor.sv
// Combinational lane compactor: gathers the occupied lanes of one beat into
// consecutive slots starting at slot 0, in ascending lane order.
module lane_compactor
    import block_pkg::*;
#(
    parameter int BLOCK_SIZE = 128,
    parameter int NUM_LANES  = 8,
    parameter int CNT_W      = cnt_w(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0]                 mask,
    input  logic [NUM_LANES-1:0][BLOCK_SIZE-1:0] data,
    output logic [NUM_LANES-1:0][BLOCK_SIZE-1:0] dense,
    output logic [CNT_W-1:0]                     count
);

    // prefix[i] = number of occupied lanes below lane i, i.e. lane i's output slot.
    logic [CNT_W-1:0] prefix [NUM_LANES+1];

    // Running popcount of the mask.
    always_comb begin
        prefix[0] = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            prefix[i+1] = prefix[i] + CNT_W'(mask[i]);
        end
    end

    // Each output slot picks the unique occupied lane whose prefix equals the
    // slot index; unfilled slots stay zero so downstream padding is clean.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_slot
        logic [BLOCK_SIZE-1:0] sel;

        // Select mux for slot gi (only lanes >= gi can land here).
        always_comb begin
            sel = '0;
            for (int i = gi; i < NUM_LANES; i++) begin
                if (mask[i] && (prefix[i] == CNT_W'(gi))) begin
                    sel = data[i];
                end
            end
        end

        assign dense[gi] = sel;
    end

    assign count = prefix[NUM_LANES];

endmodule

// File: rtl/block_packer.sv
// Streaming block packer: compacts masked input lanes, accumulates them across
// beats and emits dense OUT_BLOCKS-wide words, flushing a partial word on last.
module block_packer
    import block_pkg::*;
#(
    parameter int BLOCK_SIZE = 128,
    parameter int NUM_LANES  = 8,
    parameter int OUT_BLOCKS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_LANES-1:0]                  in_mask,
    input  logic [NUM_LANES-1:0][BLOCK_SIZE-1:0]  in_data,
    input  logic                                  in_last,
    input  logic                                  ready_4_output,
    output logic [OUT_BLOCKS-1:0][BLOCK_SIZE-1:0] out_data,
    output logic                                  out_valid,
    output logic [31:0]                           out_num,
    output logic                                  out_last
);

    // The accumulator never holds a full word between beats, so the widest
    // combined state is OUT_BLOCKS-1 held blocks plus one full beat.
    localparam int ACC_BLOCKS = OUT_BLOCKS + NUM_LANES - 1;
    localparam int CNT_W      = cnt_w(ACC_BLOCKS);
    localparam int K_W        = cnt_w(NUM_LANES);
    localparam logic [CNT_W-1:0] OB_CNT = CNT_W'(OUT_BLOCKS);

    if (!params_ok(NUM_LANES, OUT_BLOCKS)) begin : g_param_check
        $error("block_packer: requires NUM_LANES >= 1 and OUT_BLOCKS >= NUM_LANES");
    end

    typedef logic [ACC_BLOCKS-1:0][BLOCK_SIZE-1:0] acc_t;
    typedef logic [OUT_BLOCKS-1:0][BLOCK_SIZE-1:0] word_t;

    state_t           state_reg, state_next;
    acc_t             acc_reg, acc_next;
    logic [CNT_W-1:0] acc_cnt_reg, acc_cnt_next;
    word_t            out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic [31:0]      out_num_reg, out_num_next;
    logic             out_last_reg, out_last_next;

    logic [NUM_LANES-1:0][BLOCK_SIZE-1:0] dense;
    logic [K_W-1:0]   dense_cnt;
    acc_t             merged;
    acc_t             residue;
    logic [CNT_W-1:0] total;
    logic             out_free;
    logic             accept;

    lane_compactor #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_LANES  (NUM_LANES),
        .CNT_W      (K_W)
    ) u_compactor (
        .mask  (in_mask),
        .data  (in_data),
        .dense (dense),
        .count (dense_cnt)
    );

    // Append the compacted beat at position acc_cnt. Held positions at or above
    // acc_cnt are always zero, so an override leaves every other slot intact.
    for (genvar gi = 0; gi < ACC_BLOCKS; gi++) begin : g_merge
        logic [BLOCK_SIZE-1:0] blk;

        // Position gi takes dense[gi-acc_cnt] when that slot falls inside the beat.
        always_comb begin
            blk = acc_reg[gi];
            for (int d = 0; d < NUM_LANES; d++) begin
                if ((d <= gi) && (int'(acc_cnt_reg) == gi - d)) begin
                    blk = dense[d];
                end
            end
        end

        assign merged[gi] = blk;
    end

    // Blocks beyond the first output word, shifted down to position 0.
    for (genvar gi = 0; gi < ACC_BLOCKS; gi++) begin : g_residue
        if (gi + OUT_BLOCKS < ACC_BLOCKS) begin : g_take
            assign residue[gi] = merged[gi + OUT_BLOCKS];
        end else begin : g_zero
            assign residue[gi] = '0;
        end
    end

    assign total    = acc_cnt_reg + CNT_W'(dense_cnt);
    assign out_free = !out_valid_reg || ready_4_output;
    assign in_ready = !rst && (state_reg == ACCUM) && out_free;
    assign accept   = in_valid && in_ready;

    // Next-state, accumulator and output-register update.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        acc_cnt_next   = acc_cnt_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_num_next   = out_num_reg;
        out_last_next  = out_last_reg;

        // A consumed word retires unless a new one replaces it below.
        if (out_valid_reg && ready_4_output) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    if (in_last && (total > OB_CNT)) begin
                        // Overflowing last beat: full word now, residue from TAIL.
                        out_data_next  = merged[OUT_BLOCKS-1:0];
                        out_valid_next = 1'b1;
                        out_num_next   = 32'(OUT_BLOCKS);
                        out_last_next  = 1'b0;
                        acc_next       = residue;
                        acc_cnt_next   = total - OB_CNT;
                        state_next     = TAIL;
                    end else if (in_last) begin
                        // Whole packet remainder fits; may be a zero-length marker.
                        out_data_next  = merged[OUT_BLOCKS-1:0];
                        out_valid_next = 1'b1;
                        out_num_next   = 32'(total);
                        out_last_next  = 1'b1;
                        acc_next       = '0;
                        acc_cnt_next   = '0;
                    end else if (total >= OB_CNT) begin
                        out_data_next  = merged[OUT_BLOCKS-1:0];
                        out_valid_next = 1'b1;
                        out_num_next   = 32'(OUT_BLOCKS);
                        out_last_next  = 1'b0;
                        acc_next       = residue;
                        acc_cnt_next   = total - OB_CNT;
                    end else begin
                        acc_next       = merged;
                        acc_cnt_next   = total;
                    end
                end
            end
            TAIL: begin
                if (out_free) begin
                    out_data_next  = acc_reg[OUT_BLOCKS-1:0];
                    out_valid_next = 1'b1;
                    out_num_next   = 32'(acc_cnt_reg);
                    out_last_next  = 1'b1;
                    acc_next       = '0;
                    acc_cnt_next   = '0;
                    state_next     = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial packet and pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            acc_cnt_reg   <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_num_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            acc_cnt_reg   <= acc_cnt_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_num_reg   <= out_num_next;
            out_last_reg  <= out_last_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_num   = out_num_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_block_packer.sv
// Testbench for block_packer: directed scenarios plus randomized packets,
// checked against a queue-based packing model.
module tb_block_packer;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_mask;
    logic [7:0][7:0] in_data;
    logic            in_last;
    logic            ready_4_output;
    logic [7:0][7:0] out_data;
    logic            out_valid;
    logic [31:0]     out_num;
    logic            out_last;

    block_packer #(
        .BLOCK_SIZE (8),
        .NUM_LANES  (8),
        .OUT_BLOCKS (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mask        (in_mask),
        .in_data        (in_data),
        .in_last        (in_last),
        .ready_4_output (ready_4_output),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_num        (out_num),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [31:0] num;
        logic        last;
    } word_t;

    int         tests = 0;
    int         errors = 0;
    int         cyc = 0;
    int         tail_cycles = 0;
    bit         rand_ready = 1'b0;
    logic [7:0] pend_q[$];
    word_t      exp_q[$];
    word_t      got_q[$];
    int         hs_cyc_q[$];
    int         acc_cyc_q[$];
    bit         hold_prev = 1'b0;
    word_t      hold_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a packet is a stream of blocks; words are cut every
    // OUT_BLOCKS blocks, and the last beat flushes whatever remains.
    task automatic model_emit(input int n, input logic last);
        word_t w;
        w.data = '0;
        for (int j = 0; j < n; j++) w.data[j*8 +: 8] = pend_q.pop_front();
        w.num  = n;
        w.last = last;
        exp_q.push_back(w);
    endtask

    task automatic model_beat(input logic [7:0] m, input logic [63:0] d, input logic l);
        for (int i = 0; i < 8; i++) if (m[i]) pend_q.push_back(d[i*8 +: 8]);
        if (!l) begin
            if (pend_q.size() >= 8) model_emit(8, 1'b0);
        end else begin
            if (pend_q.size() > 8) model_emit(8, 1'b0);
            model_emit(pend_q.size(), 1'b1);
        end
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            hold_prev = 1'b0;
            check("rst_in_ready", in_ready, 0);
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_word.data);
                check("hold_num", out_num, hold_word.num);
                check("hold_last", out_last, hold_word.last);
            end
            if (out_valid && !ready_4_output) check("stall_in_ready", in_ready, 0);
            if (!in_ready && (!out_valid || ready_4_output)) tail_cycles++;
            if (out_valid && ready_4_output) begin
                word_t g;
                g.data = out_data; g.num = out_num; g.last = out_last;
                got_q.push_back(g);
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_word", 1, 0);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    $display("[TB] word num=%0d last=%0b data=%016h", out_num, out_last, out_data);
                    check("sb_data", out_data, e.data);
                    check("sb_num", out_num, e.num);
                    check("sb_last", out_last, e.last);
                end
            end
            if (in_valid && in_ready) begin
                acc_cyc_q.push_back(cyc);
                model_beat(in_mask, in_data, in_last);
            end
            hold_prev = out_valid && !ready_4_output;
            hold_word.data = out_data;
            hold_word.num  = out_num;
            hold_word.last = out_last;
        end
    end

    // Random backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) ready_4_output = ($urandom_range(0, 3) != 0);
    end

    // Present one beat and hold it until accepted (bounded); returns at posedge+1.
    task automatic send_beat(input logic [7:0] m, input logic [63:0] d, input logic l);
        int waited = 0;
        in_valid = 1'b1; in_mask = m; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mask  = 8'($urandom);
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom);
    endtask

    task automatic wait_words(input int n);
        int k = 0;
        while (got_q.size() < n && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_words", got_q.size() >= n, 1);
    endtask

    task automatic clear_logs();
        got_q.delete(); hs_cyc_q.delete(); acc_cyc_q.delete();
        tail_cycles = 0;
    endtask

    initial begin
        logic [63:0] d;
        int k;
        rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_data = '0; in_last = 1'b0;
        ready_4_output = 1'b1;
        repeat (3) @(posedge clk);

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_num", out_num, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready_hi", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Four full beats, last on the fourth: one word per cycle, latency 1.
        clear_logs();
        for (int b = 0; b < 4; b++) send_beat(8'hFF, {$urandom, $urandom}, b == 3);
        wait_words(4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check("full_num", got_q[i].num, 8);
            check("full_last", got_q[i].last, i == 3);
            check("full_rate", hs_cyc_q[i] - hs_cyc_q[0], i);
        end
        if (got_q.size() > 0) check("latency", hs_cyc_q[0] - acc_cyc_q[0], 1);
        check("full_no_stall", tail_cycles, 0);

        // Sparse masks followed by an overflowing last beat -> TAIL.
        clear_logs();
        d = {$urandom, $urandom}; d[7:0] = 8'hA0; d[23:16] = 8'hA2;
        send_beat(8'h05, d, 1'b0);
        d = {$urandom, $urandom}; d[7:0] = 8'hB0; d[63:56] = 8'hB7;
        send_beat(8'h81, d, 1'b0);
        send_beat(8'hFF, 64'hC7C6C5C4C3C2C1C0, 1'b1);
        wait_words(2);
        if (got_q.size() >= 2) begin
            check("tail_w1_data", got_q[0].data, 64'hC3C2C1C0B7B0A2A0);
            check("tail_w1_num", got_q[0].num, 8);
            check("tail_w1_last", got_q[0].last, 0);
            check("tail_w2_data", got_q[1].data, 64'h00000000C7C6C5C4);
            check("tail_w2_num", got_q[1].num, 4);
            check("tail_w2_last", got_q[1].last, 1);
        end
        repeat (2) begin @(posedge clk); #1; end
        check("tail_ready_low", tail_cycles, 1);

        // acc_cnt=5 plus 3 blocks exactly fills a word with nothing left over.
        clear_logs();
        send_beat(8'h1F, {$urandom, $urandom}, 1'b0);
        send_beat(8'h07, {$urandom, $urandom}, 1'b0);
        wait_words(1);
        repeat (4) begin @(posedge clk); #1; end
        check("exact_word_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("exact_num", got_q[0].num, 8);

        // Empty accumulator, mask 0 with last -> zero-length marker.
        send_beat(8'h00, {$urandom, $urandom}, 1'b1);
        wait_words(2);
        if (got_q.size() >= 2) begin
            check("marker_num", got_q[1].num, 0);
            check("marker_last", got_q[1].last, 1);
            check("marker_data", got_q[1].data, 0);
        end

        // Backpressure: pending word held for 3 cycles, then next beat lands.
        clear_logs();
        ready_4_output = 1'b0;
        send_beat(8'h03, {$urandom, $urandom}, 1'b1);
        in_valid = 1'b1; in_mask = 8'h0F; in_data = {$urandom, $urandom}; in_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_num", out_num, 2);
            check("stall_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        ready_4_output = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("resume_valid", out_valid, 1);
        check("resume_num", out_num, 4);
        check("resume_last", out_last, 1);
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end

        // Reset mid-packet discards the held blocks.
        clear_logs();
        send_beat(8'h1F, {$urandom, $urandom}, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        send_beat(8'h01, 64'h00000000000000D5, 1'b1);
        wait_words(1);
        if (got_q.size() >= 1) begin
            check("midrst_num", got_q[0].num, 1);
            check("midrst_data", got_q[0].data, 64'hD5);
            check("midrst_last", got_q[0].last, 1);
        end

        // Randomized packets under random backpressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int beats = $urandom_range(1, 5);
            for (int b = 0; b < beats; b++) begin
                logic [7:0] m;
                case ($urandom_range(0, 3))
                    0: m = 8'hFF;
                    1: m = 8'h00;
                    default: m = 8'($urandom);
                endcase
                send_beat(m, {$urandom, $urandom}, b == beats - 1);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
            end
        end
        rand_ready = 1'b0;
        ready_4_output = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_pend_empty", pend_q.size(), 0);
        check("drain_out_idle", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
